// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, constants and field helpers for the fetch stage
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  function automatic logic [4:0] rs1_of(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] instr);
    return instr[24:20];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - registered synchronous FIFO; flush wins over push/pop
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   occ_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      occ_d = occ_q + OW'(push_i) - OW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (occ_q != '0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner, imem issue logic and decode-facing queue head
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            D_ready_i,
  output logic            F_valid_o,
  output logic [XLEN-1:0] F_pc_o,
  output logic [31:0]     F_instr_o,
  output logic [4:0]      F_rs1_o,
  output logic [4:0]      F_rs2_o
);

  localparam int OW = $clog2(QDEPTH) + 1;
  localparam int LW = OW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] saved_pc_q, saved_pc_d;
  logic            inflight_q, inflight_d;

  fetch_entry_t    push_entry, head_entry;
  logic            q_valid, push, pop, head_valid;
  logic [OW-1:0]   occ;
  logic [LW-1:0]   level;

  // Head is hidden during reset so the reset cycle never shows stale contents.
  assign head_valid = q_valid & ~rst_i;
  assign pop        = head_valid & D_ready_i & ~redirect_i;
  assign push       = inflight_q & ~redirect_i;

  always_comb begin
    level      = LW'(occ) + LW'(inflight_q) - LW'(pop);
    imem_req_o = ~rst_i & ~redirect_i & (level < LW'(QDEPTH));
    pc_d       = pc_q;
    saved_pc_d = saved_pc_q;
    inflight_d = imem_req_o;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (imem_req_o) begin
      pc_d       = pc_q + 32'd4;
      saved_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      saved_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      saved_pc_q <= saved_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign imem_addr_o      = pc_q;
  assign push_entry.pc    = saved_pc_q;
  assign push_entry.instr = imem_rdata_i;

  fetch_queue #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .valid_o     (q_valid),
    .occ_o       (occ)
  );

  always_comb begin
    F_valid_o = head_valid;
    F_pc_o    = '0;
    F_instr_o = INSTR_NOP;
    F_rs1_o   = '0;
    F_rs2_o   = '0;
    if (head_valid) begin
      F_pc_o    = head_entry.pc;
      F_instr_o = head_entry.instr;
      F_rs1_o   = rs1_of(head_entry.instr);
      F_rs2_o   = rs2_of(head_entry.instr);
    end
  end

endmodule
